gps_corr_search: RTL and testbench
==================================

GPS_CORR_SEARCH -- requirements
Module: gps_corr_search

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk_in  input  1  sample clock; all state updates on rising edge.
REQ-003 rst_in_n  input  1  asynchronous active-low reset.
REQ-004 ena_in  input  1  sample strobe; when low, all counters, NCO, code generator and FSM hold.
REQ-005 sample_in  input  1  1-bit received sample (1 = negative, 0 = positive).
REQ-006 n_sat_in  input  5  PRN select (0 -> PRN1 ... 31 -> PRN32), sampled at search start.
REQ-007 doppler_in  input  8  unsigned carrier offset, added to nominal NCO word, sampled at search start.
REQ-008 start_in  input  1  single-cycle search request.
REQ-009 threshold_in  input  16  lock threshold on magnitude, sampled at search start.
REQ-010 busy_out  output  1  high from accepted start through final EVAL.
REQ-011 done_out  output  1  one-cycle pulse when search completes.
REQ-012 lock_out  output  1  best_mag >= threshold, valid from done_out until next accepted start.
REQ-013 peak_phase_out  output  16  sample offset (chip*16) of best candidate.
REQ-014 peak_mag_out  output  16  magnitude of best candidate.

Function
REQ-015 Sample counter: 14-bit, increments per enabled cycle, wraps 16367 -> 0.
REQ-016 Carrier NCO: 15-bit accumulator, increment 8000 + doppler_in, advances per enabled cycle; local sin = acc[14], local cos = acc[14] XOR acc[13].
REQ-017 Gold code replica: internal G1/G2 10-stage generator, standard GPS G2 phase-selector taps for PRN 1-32; advances one chip every 16 enabled cycles; reload to all-ones with chip/sub-chip counters = 0 on dwell start.
REQ-018 Correlation per enabled DWELL cycle: ri = gc^cos, rq = gc^sin; I accumulator += (sample_in==ri) ? +1 : -1; Q likewise with rq.
REQ-019 Accumulators: signed 15-bit, cleared at dwell start; range +/-16368, no saturation needed.
REQ-020 Magnitude = |I| + |Q|, unsigned 16-bit, computed in EVAL.
REQ-021 FSM states: IDLE, ALIGN, DWELL, EVAL, DONE.
REQ-022 IDLE: start_in=1 -> latch n_sat, doppler, threshold; candidate chip p=0, best_mag=0, best_phase=0; go ALIGN. start_in ignored in all other states.
REQ-023 ALIGN: when sample counter == p*16 on enabled cycle -> reload replica, clear accumulators, go DWELL (that cycle's sample is the first accumulated).
REQ-024 DWELL: accumulate exactly 16368 enabled samples, then EVAL.
REQ-025 EVAL (one cycle, ignores ena_in): if mag > best_mag (strict) update best_mag and best_phase = p*16; ties keep earlier phase; if p == 1022 go DONE else p += 1, go ALIGN.
REQ-026 DONE (one cycle): done_out=1, update peak_phase_out, peak_mag_out, lock_out; go IDLE.
REQ-027 Outputs peak_*/lock_out hold between searches; busy_out deasserts in the cycle done_out is high.
REQ-028 Full search latency: 1023 candidates x (align wait + 16368 samples + 1); max 2 x 16368 + 1 enabled cycles per candidate.

Reset
REQ-029 On rst_in_n low: FSM IDLE; all counters, NCO, accumulators, best registers = 0; busy_out, done_out, lock_out = 0; peak_phase_out = 0, peak_mag_out = 0.
REQ-030 Reset mid-search SHALL abort immediately without done_out; restart requires new start_in.

Verification
REQ-031 Reset: assert rst_in_n low during DWELL -> busy_out=0, outputs=0 next edge, no done_out after release.
REQ-032 Clean signal: feed gps_gen_core sin_out with PRN 5, doppler 0, signal on, noise off, ca_phase 3200; search PRN 5, doppler 0 -> done_out once, peak_phase_out=3200, peak_mag_out >= 16000, lock_out=1 with threshold 8000.
REQ-033 Wrong PRN: same stimulus, search PRN 12 -> lock_out=0 with threshold 8000, peak_mag_out < 2048.
REQ-034 Constant input: sample_in=0 whole search -> done_out once; peak_phase_out equals the first candidate attaining maximum (tie rule).
REQ-035 ena_in gating: toggle ena_in 50% during clean-signal test -> identical peak_phase_out and peak_mag_out as REQ-032.
REQ-036 start_in pulsed while busy_out=1 -> ignored; exactly one done_out per accepted start.

Source files
------------

// File: rtl/gps_corr_search.sv
// GPS C/A acquisition: serial code-phase search over one PRN / Doppler bin.
// Samples are correlated against a local carrier x Gold replica; the strongest phase is reported.
module gps_corr_search #(
    parameter int CHIPS = 1023,  // code phases searched, chips per dwell
    parameter int SPC   = 16     // samples per chip
) (
    input  logic        clk_in,
    input  logic        rst_in_n,
    input  logic        ena_in,
    input  logic        sample_in,
    input  logic [4:0]  n_sat_in,
    input  logic [7:0]  doppler_in,
    input  logic        start_in,
    input  logic [15:0] threshold_in,
    output logic        busy_out,
    output logic        done_out,
    output logic        lock_out,
    output logic [15:0] peak_phase_out,
    output logic [15:0] peak_mag_out
);
    localparam int          SW       = (SPC > 1) ? $clog2(SPC) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(SPC - 1);
    localparam logic [13:0] CNT_LAST = 14'(CHIPS * SPC - 1);
    localparam logic [9:0]  P_LAST   = 10'(CHIPS - 1);

    typedef enum logic [2:0] {IDLE, ALIGN, DWELL, EVAL, DONE} state_t;
    state_t state, state_nx;

    logic [13:0]        cnt, dcnt;
    logic [14:0]        nco;
    logic [9:0]         g1, g2, p;
    logic [SW-1:0]      sub;
    logic signed [14:0] acc_i, acc_q;
    logic [4:0]         sat_q;
    logic [7:0]         dop_q;
    logic [15:0]        thr_q, best_mag, best_phase;

    logic               align_hit, acc_en, last_eval, better;
    logic [9:0]         g1_cur, g2_cur;
    logic [SW-1:0]      sub_cur;
    logic [7:0]         taps;
    logic               gc, ri, rq;
    logic [14:0]        abs_i, abs_q;
    logic [15:0]        mag, cand_phase, fin_mag, fin_phase;

    // G2 phase-selector stages (0-based) for PRN 1..32
    function automatic logic [7:0] g2_taps(input logic [4:0] n);
        case (n)
            5'd0:  g2_taps = {4'd1, 4'd5}; 5'd1:  g2_taps = {4'd2, 4'd6};
            5'd2:  g2_taps = {4'd3, 4'd7}; 5'd3:  g2_taps = {4'd4, 4'd8};
            5'd4:  g2_taps = {4'd0, 4'd8}; 5'd5:  g2_taps = {4'd1, 4'd9};
            5'd6:  g2_taps = {4'd0, 4'd7}; 5'd7:  g2_taps = {4'd1, 4'd8};
            5'd8:  g2_taps = {4'd2, 4'd9}; 5'd9:  g2_taps = {4'd1, 4'd2};
            5'd10: g2_taps = {4'd2, 4'd3}; 5'd11: g2_taps = {4'd4, 4'd5};
            5'd12: g2_taps = {4'd5, 4'd6}; 5'd13: g2_taps = {4'd6, 4'd7};
            5'd14: g2_taps = {4'd7, 4'd8}; 5'd15: g2_taps = {4'd8, 4'd9};
            5'd16: g2_taps = {4'd0, 4'd3}; 5'd17: g2_taps = {4'd1, 4'd4};
            5'd18: g2_taps = {4'd2, 4'd5}; 5'd19: g2_taps = {4'd3, 4'd6};
            5'd20: g2_taps = {4'd4, 4'd7}; 5'd21: g2_taps = {4'd5, 4'd8};
            5'd22: g2_taps = {4'd0, 4'd2}; 5'd23: g2_taps = {4'd3, 4'd5};
            5'd24: g2_taps = {4'd4, 4'd6}; 5'd25: g2_taps = {4'd5, 4'd7};
            5'd26: g2_taps = {4'd6, 4'd8}; 5'd27: g2_taps = {4'd7, 4'd9};
            5'd28: g2_taps = {4'd0, 4'd5}; 5'd29: g2_taps = {4'd1, 4'd6};
            5'd30: g2_taps = {4'd2, 4'd7}; default: g2_taps = {4'd3, 4'd8};
        endcase
    endfunction

    // On the alignment cycle the replica restarts from its load state for this very sample
    assign align_hit = (state == ALIGN) && ena_in && (cnt == 14'(p * SPC));
    assign acc_en    = ena_in && (align_hit || state == DWELL);
    assign g1_cur    = align_hit ? '1 : g1;
    assign g2_cur    = align_hit ? '1 : g2;
    assign sub_cur   = align_hit ? '0 : sub;
    assign taps      = g2_taps(sat_q);
    assign gc        = g1_cur[9] ^ g2_cur[taps[7:4]] ^ g2_cur[taps[3:0]];
    assign ri        = gc ^ nco[14] ^ nco[13];
    assign rq        = gc ^ nco[14];

    assign abs_i      = acc_i[14] ? 15'(-acc_i) : 15'(acc_i);
    assign abs_q      = acc_q[14] ? 15'(-acc_q) : 15'(acc_q);
    assign mag        = {1'b0, abs_i} + {1'b0, abs_q};
    assign cand_phase = 16'(p * SPC);
    assign better     = mag > best_mag;
    assign last_eval  = (state == EVAL) && (p == P_LAST);
    assign fin_mag    = better ? mag : best_mag;
    assign fin_phase  = better ? cand_phase : best_phase;

    always_comb begin
        state_nx = state;
        busy_out = 1'b0;
        done_out = 1'b0;
        case (state)
            IDLE:  if (start_in) state_nx = ALIGN;
            ALIGN: begin busy_out = 1'b1; if (align_hit) state_nx = DWELL; end
            DWELL: begin busy_out = 1'b1; if (ena_in && dcnt == CNT_LAST) state_nx = EVAL; end
            EVAL:  begin busy_out = 1'b1; state_nx = (p == P_LAST) ? DONE : ALIGN; end
            DONE:  begin done_out = 1'b1; state_nx = IDLE; end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) state <= IDLE;
        else           state <= state_nx;
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            cnt <= '0; dcnt <= '0; nco <= '0; sub <= '0; p <= '0;
            g1 <= '1; g2 <= '1;
            acc_i <= '0; acc_q <= '0;
            sat_q <= '0; dop_q <= '0; thr_q <= '0;
            best_mag <= '0; best_phase <= '0;
            lock_out <= 1'b0; peak_phase_out <= '0; peak_mag_out <= '0;
        end else begin
            if (ena_in) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 14'd1;
                nco <= nco + 15'd8000 + 15'(dop_q);
            end
            if (acc_en) begin
                sub  <= (sub_cur == SUB_LAST) ? '0 : sub_cur + 1'b1;
                g1   <= (sub_cur == SUB_LAST) ? {g1_cur[8:0], g1_cur[2] ^ g1_cur[9]} : g1_cur;
                g2   <= (sub_cur == SUB_LAST) ? {g2_cur[8:0], g2_cur[1] ^ g2_cur[2] ^ g2_cur[5]
                                                 ^ g2_cur[7] ^ g2_cur[8] ^ g2_cur[9]} : g2_cur;
                acc_i <= (align_hit ? 15'sd0 : acc_i) + ((sample_in == ri) ? 15'sd1 : -15'sd1);
                acc_q <= (align_hit ? 15'sd0 : acc_q) + ((sample_in == rq) ? 15'sd1 : -15'sd1);
                dcnt  <= align_hit ? 14'd1 : dcnt + 14'd1;
            end
            if (state == IDLE && start_in) begin
                sat_q <= n_sat_in; dop_q <= doppler_in; thr_q <= threshold_in;
                p <= '0; best_mag <= '0; best_phase <= '0;
            end
            if (state == EVAL) begin
                if (better) begin
                    best_mag   <= mag;
                    best_phase <= cand_phase;
                end
                if (p != P_LAST) p <= p + 10'd1;
            end
            // Results land together with the DONE state so they are valid while done_out is high
            if (last_eval) begin
                peak_mag_out   <= fin_mag;
                peak_phase_out <= fin_phase;
                lock_out       <= fin_mag >= thr_q;
            end
        end
    end
endmodule

// File: tb/tb_gps_corr_search.sv
// Directed bench for gps_corr_search on a shortened code (10 chips x 4 samples) so searches finish quickly.
module tb_gps_corr_search;
    localparam int CHIPS = 10;
    localparam int SPC   = 4;
    localparam int L     = CHIPS * SPC;

    logic        clk_in = 1'b0, rst_in_n, ena_in, sample_in, start_in;
    logic [4:0]  n_sat_in;
    logic [7:0]  doppler_in;
    logic [15:0] threshold_in;
    logic        busy_out, done_out, lock_out;
    logic [15:0] peak_phase_out, peak_mag_out;

    int checks = 0, failures = 0;
    int k;        // enabled samples since reset release
    int n_done;
    int exp_mag, exp_phase, exp_lock;

    always #5 clk_in = ~clk_in;

    gps_corr_search #(.CHIPS(CHIPS), .SPC(SPC)) dut (
        .clk_in(clk_in), .rst_in_n(rst_in_n), .ena_in(ena_in), .sample_in(sample_in),
        .n_sat_in(n_sat_in), .doppler_in(doppler_in), .start_in(start_in),
        .threshold_in(threshold_in), .busy_out(busy_out), .done_out(done_out),
        .lock_out(lock_out), .peak_phase_out(peak_phase_out), .peak_mag_out(peak_mag_out)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // First ten C/A chips, octal as published in the ICD
    function automatic logic [9:0] code10(input int prn);
        case (prn)
            1:       return 10'o1440;
            5:       return 10'o1133;
            12:      return 10'o1750;
            default: return 10'o0000;
        endcase
    endfunction

    function automatic logic chip(input int prn, input int j);
        logic [9:0] c;
        c = code10(prn);
        return c[9 - j];
    endfunction

    function automatic int nco_at(input int kk);
        return (kk * 8000) % 32768;
    endfunction

    // Received sample: PRN tprn delayed by tph chips riding on the local carrier; tprn 0 = constant 0
    function automatic logic sig(input int tprn, input int tph, input int kk);
        int c, a;
        if (tprn == 0) return 1'b0;
        c = kk % L;
        a = nco_at(kk);
        return chip(tprn, ((c - tph * SPC + L) % L) / SPC) ^ a[14] ^ a[13];
    endfunction

    // Dwell p starts at the first sample index after start whose counter is p*SPC;
    // consecutive dwells are L+SPC enabled samples apart.
    task automatic model(input int sprn, input int tprn, input int tph, input int thr, input int kst);
        int s0, s, ci, cq, m, a;
        logic r, ri, rq, smp;
        s0 = ((kst + L) / L) * L;
        exp_mag = 0;
        exp_phase = 0;
        for (int pp = 0; pp < CHIPS; pp++) begin
            s = s0 + pp * (L + SPC);
            ci = 0;
            cq = 0;
            for (int n = 0; n < L; n++) begin
                a   = nco_at(s + n);
                r   = chip(sprn, n / SPC);
                ri  = r ^ a[14] ^ a[13];
                rq  = r ^ a[14];
                smp = sig(tprn, tph, s + n);
                ci += (smp == ri) ? 1 : -1;
                cq += (smp == rq) ? 1 : -1;
            end
            m = ((ci < 0) ? -ci : ci) + ((cq < 0) ? -cq : cq);
            if (m > exp_mag) begin
                exp_mag = m;
                exp_phase = pp * SPC;
            end
        end
        exp_lock = (exp_mag >= thr) ? 1 : 0;
    endtask

    task automatic tick(input logic en, input logic st, input int tprn, input int tph);
        ena_in    = en;
        start_in  = st;
        sample_in = en ? sig(tprn, tph, k) : logic'($urandom_range(0, 1));
        @(posedge clk_in);
        if (en) k++;
        #1;
        if (done_out) n_done++;
        start_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_in_n = 1'b0; ena_in = 1'b0; start_in = 1'b0; sample_in = 1'b0;
        n_sat_in = '0; doppler_in = '0; threshold_in = '0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in_n = 1'b1;
        k = 0;
    endtask

    task automatic search(input string nm, input int sprn, input int tprn, input int tph,
                          input int thr, input bit gate, input bit poke);
        int cyc;
        n_sat_in = 5'(sprn - 1); threshold_in = 16'(thr); doppler_in = '0;
        model(sprn, tprn, tph, thr, k);
        n_done = 0;
        tick(1'b1, 1'b1, tprn, tph);
        chk({nm, " busy after start"}, int'(busy_out), 1);
        cyc = 0;
        while (n_done == 0 && cyc < 4000) begin
            if (poke) begin
                n_sat_in = 5'($urandom); threshold_in = 16'($urandom); doppler_in = 8'($urandom);
            end
            tick(gate ? logic'($urandom_range(0, 1)) : 1'b1, poke && (cyc % 97 == 50), tprn, tph);
            if (done_out) chk({nm, " busy in done cycle"}, int'(busy_out), 0);
            cyc++;
        end
        chk({nm, " done seen"}, n_done, 1);
        chk({nm, " phase"}, int'(peak_phase_out), exp_phase);
        chk({nm, " mag"}, int'(peak_mag_out), exp_mag);
        chk({nm, " lock"}, int'(lock_out), exp_lock);
        n_sat_in = '0; threshold_in = '0; doppler_in = '0;
        repeat (60) tick(1'b1, 1'b0, tprn, tph);
        chk({nm, " single done"}, n_done, 1);
        chk({nm, " phase held"}, int'(peak_phase_out), exp_phase);
    endtask

    initial begin
        int s0;
        do_reset();
        chk("reset busy", int'(busy_out), 0);
        chk("reset done", int'(done_out), 0);
        chk("reset lock", int'(lock_out), 0);
        chk("reset phase", int'(peak_phase_out), 0);
        chk("reset mag", int'(peak_mag_out), 0);

        // Clean PRN5 at chip 3, start pokes while busy
        search("clean", 5, 5, 3, 30, 1'b0, 1'b1);
        chk("clean phase is 12", int'(peak_phase_out), 12);
        chk("clean mag >= L", int'(peak_mag_out >= 16'(L)), 1);
        chk("clean lock", int'(lock_out), 1);

        // Abort mid-dwell with async reset
        n_sat_in = 5'd4; threshold_in = 16'd30; n_done = 0;
        tick(1'b1, 1'b1, 5, 3);
        s0 = ((k - 1 + L) / L) * L;
        while (k < s0 + 10) tick(1'b1, 1'b0, 5, 3);
        chk("abort busy before", int'(busy_out), 1);
        #2 rst_in_n = 1'b0;
        #1;
        chk("abort busy", int'(busy_out), 0);
        chk("abort lock", int'(lock_out), 0);
        chk("abort phase", int'(peak_phase_out), 0);
        chk("abort mag", int'(peak_mag_out), 0);
        @(posedge clk_in);
        #1;
        rst_in_n = 1'b1;
        k = 0;
        repeat (700) tick(1'b1, 1'b0, 5, 3);
        chk("abort no done", n_done, 0);
        chk("abort idle", int'(busy_out), 0);

        do_reset();
        search("wrong prn", 12, 5, 3, 30, 1'b0, 1'b0);

        do_reset();
        search("const", 1, 0, 0, 30, 1'b0, 1'b0);

        do_reset();
        search("gated", 5, 5, 3, 30, 1'b1, 1'b0);
        chk("gated phase is 12", int'(peak_phase_out), 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
